// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the arbitrated UART transmitter.
package uart_pkg;

    localparam int unsigned CPB_DEFAULT = 434;
    localparam int unsigned FRAME_BITS  = 10;

    typedef enum logic [1:0] {IDLE, SEND, GAP} arb_state_e;
    typedef enum logic [1:0] {C_IDLE, C_START, C_DATA, C_STOP} core_state_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_core.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit, each CPB clocks long.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned CPB = CPB_DEFAULT
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned    BW       = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CPB - 1);

    core_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_MAX);
    assign tx      = tx_q;
    assign busy    = (state_q != C_IDLE);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done    = 1'b0;
        case (state_q)
            C_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = C_START;
                    shift_d = data;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            C_START, C_DATA: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 1'b1;
                    // bit_q == 8 is the last data bit; the next bit is the stop bit
                    if (bit_q == 4'd8) begin
                        state_d = C_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        state_d = C_DATA;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            default: begin
                baud_d = baud_q + 1'b1;
                if (bit_end) begin
                    done    = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = C_IDLE;
                    tx_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with message lock sharing one UART transmit line among NREQ requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CPB  = CPB_DEFAULT
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic              tx,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              tx_done
);

    arb_state_e      state_q, state_d;
    logic [2:0]      rr_q, rr_d;
    logic [2:0]      grant_q, grant_d;
    logic            lock_q, lock_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic            core_start, core_done;
    logic [7:0]      core_data;
    logic [NREQ-1:0] owner_oh, eligible;
    logic            owner_req, win_found, win_last;
    int unsigned     rr_eff, win;

    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign tx_done  = core_done;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        lock_d     = lock_q;
        ack_d      = '0;
        core_start = 1'b0;
        core_data  = '0;
        eligible   = req;
        rr_eff     = 32'(rr_q);
        win_found  = 1'b0;
        win        = 0;
        win_last   = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            owner_oh[j] = (j == 32'(grant_q));
        end
        owner_req = |(owner_oh & req);
        case (state_q)
            SEND: begin
                if (core_done) state_d = GAP;
            end
            default: begin
                // GAP arbitrates exactly like IDLE so consecutive frames keep one idle-high cycle
                if (lock_q) begin
                    if (owner_req) begin
                        eligible = owner_oh;
                    end else begin
                        lock_d = 1'b0;
                        rr_eff = rr_next(32'(grant_q), NREQ);
                    end
                end
                for (int unsigned k = 0; k < NREQ; k++) begin
                    for (int unsigned j = 0; j < NREQ; j++) begin
                        if (!win_found && eligible[j] && (j == (rr_eff + k) % NREQ)) begin
                            win_found = 1'b1;
                            win       = j;
                            win_last  = req_last[j];
                            core_data = req_data[8*j +: 8];
                        end
                    end
                end
                for (int unsigned j = 0; j < NREQ; j++) begin
                    ack_d[j] = win_found && (j == win);
                end
                if (win_found) begin
                    state_d    = SEND;
                    core_start = 1'b1;
                    grant_d    = 3'(win);
                    lock_d     = ~win_last;
                    rr_d       = win_last ? 3'(rr_next(win, NREQ)) : 3'(rr_eff);
                end else begin
                    state_d = IDLE;
                    rr_d    = 3'(rr_eff);
                end
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            ack_q   <= ack_d;
        end
    end

    uart_tx_core #(.CPB(CPB)) u_core (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .start   (core_start),
        .data    (core_data),
        .tx      (tx),
        .busy    (busy),
        .done    (core_done)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: a queue-based arbitration model predicts grant order; a line monitor decodes frames.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CPB   = 434;
    localparam int unsigned FRAME = 10 * CPB;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } item_t;

    typedef struct {
        int unsigned id;
        logic [7:0]  data;
        bit          b2b;
    } exp_t;

    logic              clk_50M = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   ack;
    logic              tx, busy, tx_done;
    logic [2:0]        grant_id;

    int checks = 0;
    int errors = 0;

    item_t stage_q[NREQ][$];
    item_t drv_q[NREQ][$];
    exp_t  exp_q[$];

    int unsigned m_rr = 0, m_owner = 0;
    bit          m_lock = 0;

    int unsigned cyc = 0;
    bit          in_frame = 0;
    int unsigned idle_bad = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .CPB(CPB)) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .tx       (tx),
        .busy     (busy),
        .grant_id (grant_id),
        .tx_done  (tx_done)
    );

    initial forever #10 clk_50M = ~clk_50M;
    initial forever begin
        @(posedge clk_50M);
        cyc++;
    end

    // Reference model: replays round-robin with message lock over everything staged at once.
    task automatic commit();
        item_t pend[NREQ][$];
        item_t it;
        exp_t  e;
        bit    first = 1;
        bit    any;
        int    w;
        for (int i = 0; i < NREQ; i++) pend[i] = stage_q[i];
        forever begin
            any = 0;
            for (int i = 0; i < NREQ; i++) if (pend[i].size() > 0) any = 1;
            if (!any) break;
            if (m_lock && pend[m_owner].size() == 0) begin
                m_lock = 0;
                m_rr   = (m_owner + 1) % NREQ;
            end
            w = -1;
            if (m_lock) w = int'(m_owner);
            else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && pend[(m_rr + k) % NREQ].size() > 0) w = int'((m_rr + k) % NREQ);
                end
            end
            it     = pend[w].pop_front();
            e.id   = w;
            e.data = it.data;
            e.b2b  = !first;
            exp_q.push_back(e);
            first = 0;
            if (it.last) begin
                m_lock = 0;
                m_rr   = (w + 1) % NREQ;
            end else begin
                m_lock  = 1;
                m_owner = w;
            end
        end
        if (m_lock) begin
            m_lock = 0;
            m_rr   = (m_owner + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            foreach (stage_q[i][n]) drv_q[i].push_back(stage_q[i][n]);
            stage_q[i].delete();
        end
    endtask

    task automatic stage(input int id, input logic [7:0] d, input logic l);
        item_t it;
        it.data = d;
        it.last = l;
        stage_q[id].push_back(it);
    endtask

    task automatic do_reset();
        @(negedge clk_50M);
        rst_n  = 1'b0;
        m_rr   = 0;
        m_lock = 0;
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
    endtask

    function automatic bit drv_empty();
        for (int i = 0; i < NREQ; i++) if (drv_q[i].size() > 0) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input string name, input int unsigned nframes);
        int unsigned n = 0;
        int unsigned limit = nframes * (FRAME + 1) + 50;
        while (!(exp_q.size() == 0 && drv_empty() && !in_frame && req == '0) && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required done within %0d", name, n, limit);
            for (int i = 0; i < NREQ; i++) drv_q[i].delete();
            exp_q.delete();
            do_reset();
        end
        repeat (3) @(negedge clk_50M);
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL %s_idle_line: %0d bad idle cycles, required 0", name, idle_bad);
        end
        idle_bad = 0;
    endtask

    // Driver: holds each requester's head byte until its ack, never re-asserting in the ack cycle.
    initial begin
        item_t tmp;
        req = '0;
        req_data = '0;
        req_last = '0;
        forever begin
            @(negedge clk_50M);
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                    if (drv_q[i].size() > 0) tmp = drv_q[i].pop_front();
                end else if (!req[i] && drv_q[i].size() > 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = drv_q[i][0].data;
                    req_last[i] = drv_q[i][0].last;
                end
            end
        end
    end

    // Monitor: pops the expected grant on every ack and checks the resulting frame bit by bit.
    initial begin
        exp_t            cur;
        bit              have_cur = 0;
        int unsigned     ack_cyc = 0, fs = 0, last_fs = 0, off, bi;
        int unsigned     bad = 0, bad_off = 0;
        logic [7:0]      rx_msg = '0;
        logic            etx;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clk_50M);
            if (!rst_n) begin
                in_frame = 0;
                have_cur = 0;
                continue;
            end
            if (ack != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: ack=%b grant_id=%0d, required no ack", ack, grant_id);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    ack_cyc = cyc;
                    oh = '0;
                    oh[cur.id] = 1'b1;
                    if (ack !== oh || grant_id !== 3'(cur.id)) begin
                        errors++;
                        $display("FAIL grant: ack=%b grant_id=%0d, required ack=%b grant_id=%0d",
                                 ack, grant_id, oh, cur.id);
                    end
                end
            end
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1;
                    fs = cyc;
                    bad = 0;
                    rx_msg = '0;
                    checks++;
                    if (!have_cur || ack_cyc != cyc) begin
                        errors++;
                        $display("FAIL start_align: start bit at cycle %0d, required ack cycle %0d (ack seen=%0d)",
                                 cyc, ack_cyc, have_cur);
                    end
                    if (have_cur && cur.b2b) begin
                        checks++;
                        if (fs - last_fs != FRAME + 1) begin
                            errors++;
                            $display("FAIL start_spacing: %0d cycles between start bits, required %0d",
                                     fs - last_fs, FRAME + 1);
                        end
                    end
                    have_cur = 0;
                end else if (busy !== 1'b0 || tx_done !== 1'b0 || tx !== 1'b1) begin
                    idle_bad++;
                end
            end
            if (in_frame) begin
                off = cyc - fs;
                bi  = off / CPB;
                etx = (bi == 0) ? 1'b0 : (bi >= 9) ? 1'b1 : cur.data[bi-1];
                if (tx !== etx || busy !== 1'b1 || tx_done !== (off == FRAME - 1)) begin
                    if (bad == 0) bad_off = off;
                    bad++;
                end
                if (bi >= 1 && bi <= 8 && off == bi * CPB + CPB / 2) rx_msg[bi-1] = tx;
                if (off == FRAME - 1) begin
                    checks++;
                    if (rx_msg !== cur.data) begin
                        errors++;
                        $display("FAIL rx_msg: received %h, required %h (requester %0d)", rx_msg, cur.data, cur.id);
                    end
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL frame_timing: %0d bad cycles, first at offset %0d, required 0",
                                 bad, bad_off);
                    end
                    in_frame = 0;
                    last_fs  = fs;
                end
            end
        end
    end

    initial begin
        int unsigned n;
        int a, b;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50M);
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || ack !== '0 || grant_id !== 3'd0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b ack=%b grant_id=%0d tx_done=%b, required 1 0 0000 0 0",
                     tx, busy, ack, grant_id, tx_done);
        end
        @(negedge clk_50M);
        rst_n = 1'b1;

        stage(2, 8'hA5, 1'b1);
        commit();
        wait_idle("single_byte", 1);

        do_reset();
        stage(0, 8'($urandom), 1'b1);
        stage(0, 8'($urandom), 1'b1);
        for (int i = 1; i < NREQ; i++) stage(i, 8'($urandom), 1'b1);
        commit();
        wait_idle("all_request", 5);

        stage(1, 8'($urandom), 1'b0);
        stage(1, 8'($urandom), 1'b0);
        stage(1, 8'($urandom), 1'b1);
        stage(0, 8'($urandom), 1'b1);
        stage(3, 8'($urandom), 1'b1);
        commit();
        wait_idle("message_lock", 5);

        do_reset();
        stage(0, 8'($urandom), 1'b0);
        stage(2, 8'($urandom), 1'b1);
        commit();
        wait_idle("lock_drop", 2);

        stage(2, 8'h3C, 1'b1);
        commit();
        n = 0;
        while (!in_frame && n < 100) begin
            @(negedge clk_50M);
            n++;
        end
        repeat (4 * CPB + CPB / 2) @(negedge clk_50M);
        rst_n  = 1'b0;
        m_rr   = 0;
        m_lock = 0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || ack !== '0 || grant_id !== 3'd0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: tx=%b busy=%b ack=%b grant_id=%0d tx_done=%b, required 1 0 0000 0 0",
                     tx, busy, ack, grant_id, tx_done);
        end
        stage(3, 8'($urandom), 1'b1);
        stage(1, 8'($urandom), 1'b1);
        commit();
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        wait_idle("after_reset", 2);

        a = int'($urandom_range(0, NREQ - 1));
        b = (a + int'($urandom_range(1, NREQ - 1))) % NREQ;
        stage(a, 8'($urandom), 1'($urandom));
        stage(b, 8'($urandom), 1'($urandom));
        commit();
        wait_idle("random_pair", 2);
        stage(int'($urandom_range(0, NREQ - 1)), 8'($urandom), 1'($urandom));
        commit();
        wait_idle("random_single", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (99000) @(posedge clk_50M);
        errors++;
        $display("FAIL global_timeout: bench still running at cycle %0d, required finish earlier", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
